// File: rtl/jamma_input_scanner.sv
// JAMMA player-select scanner: settle-then-sample of the shared JJOY bus, per-player debounce, coin stretch.
// Optional build macro JAMMA_SOCD_EN enables SOCD cleaning (opposing directions cancel) on each sample.
module jamma_input_scanner #(
    parameter int SETTLE_CYCLES    = 8,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int COIN_HOLD_SCANS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic [5:0] joystick_kbd,
    output logic       jselect,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] coin,
    output logic       scan_tick
);

    typedef enum logic [1:0] {SETTLE1, SAMPLE1, SETTLE2, SAMPLE2} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DB_LAST     = 4'(DEBOUNCE_SAMPLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(COIN_HOLD_SCANS);

    state_t      state;
    logic [7:0]  settle_cnt;
    logic [7:0]  jjoy_p0, jjoy_p1;
    logic [1:0]  jcoin_p0, jcoin_p1;
    logic [31:0] cnt1, cnt2, cnt1_n, cnt2_n;
    logic [7:0]  joy1_n, joy2_n, samp1, samp2;
    logic [1:0]  coin_db, coin_db_n, coin_n;
    logic [7:0]  coin_cnt, coin_cnt_n;
    logic [15:0] hold, hold_n;

    function automatic logic [7:0] socd_clean(input logic [7:0] s);
        logic [7:0] r;
`ifdef JAMMA_SOCD_EN
        r = s;
        if (!s[0] && !s[1]) r[1:0] = 2'b11;
        if (!s[2] && !s[3]) r[3:2] = 2'b11;
`else
        r = s;
`endif
        return r;
    endfunction

    // Returns {next output bit, next agreement count}.
    function automatic logic [4:0] debounce_bit(input logic s, input logic o, input logic [3:0] c);
        if (s == o)       return {o, 4'd0};
        if (c == DB_LAST) return {s, 4'd0};
        return {o, c + 4'd1};
    endfunction

    // Pad synchronisers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jjoy_p0  <= 8'hFF;
            jjoy_p1  <= 8'hFF;
            jcoin_p0 <= 2'b11;
            jcoin_p1 <= 2'b11;
        end else begin
            jjoy_p0  <= jjoy;
            jjoy_p1  <= jjoy_p0;
            jcoin_p0 <= jcoin;
            jcoin_p1 <= jcoin_p0;
        end
    end

    assign samp1 = socd_clean(jjoy_p1 & {2'b11, joystick_kbd});
    assign samp2 = socd_clean(jjoy_p1);

    always_comb begin
        joy1_n     = joy1;
        joy2_n     = joy2;
        cnt1_n     = cnt1;
        cnt2_n     = cnt2;
        coin_db_n  = coin_db;
        coin_cnt_n = coin_cnt;
        hold_n     = hold;
        coin_n     = coin;
        for (int i = 0; i < 8; i++) begin
            {joy1_n[i], cnt1_n[4*i +: 4]} = debounce_bit(samp1[i], joy1[i], cnt1[4*i +: 4]);
            {joy2_n[i], cnt2_n[4*i +: 4]} = debounce_bit(samp2[i], joy2[i], cnt2[4*i +: 4]);
        end
        for (int i = 0; i < 2; i++) begin
            {coin_db_n[i], coin_cnt_n[4*i +: 4]} =
                debounce_bit(jcoin_p1[i], coin_db[i], coin_cnt[4*i +: 4]);
            // Only a fresh edge with an idle hold counter reloads it.
            if (coin_db[i] && !coin_db_n[i] && hold[8*i +: 8] == 8'd0)
                hold_n[8*i +: 8] = HOLD_LOAD;
            else if (hold[8*i +: 8] != 8'd0)
                hold_n[8*i +: 8] = hold[8*i +: 8] - 8'd1;
            coin_n[i] = coin_db_n[i] & (hold_n[8*i +: 8] == 8'd0);
        end
    end

    // Scan FSM and per-player sample registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SETTLE1;
            settle_cnt <= 8'd0;
            jselect    <= 1'b0;
            scan_tick  <= 1'b0;
            joy1       <= 8'hFF;
            joy2       <= 8'hFF;
            cnt1       <= 32'd0;
            cnt2       <= 32'd0;
            coin_db    <= 2'b11;
            coin_cnt   <= 8'd0;
            hold       <= 16'd0;
            coin       <= 2'b11;
        end else begin
            jselect   <= (state == SETTLE2) || (state == SAMPLE2);
            scan_tick <= (state == SAMPLE2);
            case (state)
                SETTLE1, SETTLE2: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 8'd0;
                        state      <= (state == SETTLE1) ? SAMPLE1 : SAMPLE2;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                SAMPLE1: begin
                    joy1     <= joy1_n;
                    cnt1     <= cnt1_n;
                    coin_db  <= coin_db_n;
                    coin_cnt <= coin_cnt_n;
                    hold     <= hold_n;
                    coin     <= coin_n;
                    state    <= SETTLE2;
                end
                default: begin
                    joy2  <= joy2_n;
                    cnt2  <= cnt2_n;
                    state <= SETTLE1;
                end
            endcase
        end
    end

endmodule
